// File: rtl/rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue
//
// Purpose
//   Writer side of the 32 x DATA_W register file write port.
//   Two result sources share the single port:
//     - ALU results, which are never back-pressured.
//     - Load results, offered with a valid/ready handshake.
//   A load that cannot use the port waits in a small FIFO. The block also
//   exports a bitmap of destination registers that still have a live load
//   queued, so decode can detect hazards.
//
// Arbitration and ordering
//   - At most one register-file write is made per cycle.
//   - The ALU has priority. Otherwise the FIFO head pops.
//   - A younger ALU write to rd cancels every queued load to the same rd,
//     including a load that is accepted in the same cycle.
//   - A cancelled entry still pops in order, but it does not assert rf_we.
//
// Ports
//   clk        in   1             clock, all state updates on posedge
//   reset      in   1             asynchronous active-high clear
//   flush      in   1             synchronous queue clear; drops this cycle's inputs
//   alu_valid  in   1             ALU result present (always accepted)
//   alu_rd     in   5             ALU destination register
//   alu_data   in   DATA_W        ALU result
//   ld_valid   in   1             load result offered
//   ld_ready   out  1             FIFO can accept a load (state only)
//   ld_rd      in   5             load destination register
//   ld_data    in   DATA_W        load result
//   rf_we      out  1             register file write enable (registered)
//   rf_rd      out  5             register file destination (registered)
//   rf_wdata   out  DATA_W        register file write data (registered)
//   pending    out  32            bit r set while a live queued load targets xr
//   count      out  log2(DEPTH)+1 FIFO occupancy, cancelled entries included
// -----------------------------------------------------------------------------
module rf_writeback_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage
    //   rd/data live in plain arrays that are written only on enqueue.
    //   Per-entry liveness is reset, because it gates pending and rf_we.
    // ------------------------------------------------------------------
    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    // ------------------------------------------------------------------
    // Port arbitration
    //   An ALU write to x0 is a no-op and leaves the port free for the
    //   FIFO head. A load to x0 completes the handshake but is never stored.
    // ------------------------------------------------------------------
    logic alu_write;
    logic ld_push;
    logic head_pop;
    logic head_live;
    logic same_cycle_kill;

    assign ld_ready        = (count_q < FULL);
    assign alu_write       = alu_valid && (alu_rd != 5'd0);
    assign ld_push         = !flush && ld_valid && ld_ready && (ld_rd != 5'd0);
    assign head_pop        = !flush && !alu_write && (count_q != '0);
    assign head_live       = live_q[head_q];
    // The load accepted this cycle is older than the ALU result beside it.
    assign same_cycle_kill = alu_write && (ld_rd == alu_rd);

    // ------------------------------------------------------------------
    // Per-entry event decode
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] cancel_hit;
    logic [DEPTH-1:0] pop_hit;
    logic [DEPTH-1:0] push_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Slots that are not occupied have live=0, so a stale rd match
            // on them does nothing.
            assign cancel_hit[gi] = alu_write && (rd_q[gi] == alu_rd);
            assign pop_hit[gi]    = head_pop && (head_q == PTR_W'(gi));
            assign push_hit[gi]   = ld_push && (tail_q == PTR_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Liveness update
    //   The steps are applied in order: cancel, then pop, then push.
    //   The pushed slot can never also be the popped slot, because a push
    //   and a pop only share a slot when the FIFO is full, and then
    //   ld_ready is 0.
    // ------------------------------------------------------------------
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cancel_hit[i]) begin
                live_d[i] = 1'b0;
            end
            if (pop_hit[i]) begin
                live_d[i] = 1'b0;
            end
            if (push_hit[i]) begin
                live_d[i] = !same_cycle_kill;
            end
        end
        if (flush) begin
            live_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // The pointer width equals log2(DEPTH), so +1 wraps naturally.
            if (head_pop) begin
                head_d = head_q + 1'b1;
            end
            if (ld_push) begin
                tail_d = tail_q + 1'b1;
            end
            case ({ld_push, head_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    //   rf_rd and rf_wdata hold their last values when no write is made.
    //   Only rf_we qualifies them.
    // ------------------------------------------------------------------
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (flush) begin
            rf_we_d = 1'b0;
        end else if (alu_write) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = alu_rd;
            rf_wdata_d = alu_data;
        end else if (head_pop) begin
            // A cancelled head is dropped silently.
            rf_we_d = head_live;
            if (head_live) begin
                rf_rd_d    = rd_q[head_q];
                rf_wdata_d = data_q[head_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending bitmap
    //   This is built from state only. The bit for a load therefore drops
    //   in the cycle that rf_we presents that load.
    // ------------------------------------------------------------------
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending[rd_q[i]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            live_q     <= live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage has no reset. Entries are meaningful only while live.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            rd_q[tail_q]   <= ld_rd;
            data_q[tail_q] <= ld_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = count_q;

endmodule
